// File: rtl/kernel2_mul_pkg.sv
// Shared types, widths and output-conversion helpers for the kernel2
// pipelined multiplier.
package kernel2_mul_pkg;

  // Largest operand widths that map onto one DSP48 cascade.
  localparam int MAX_DIN0_WIDTH = 25;
  localparam int MAX_DIN1_WIDTH = 18;
  localparam int MAX_PROD_WIDTH = MAX_DIN0_WIDTH + MAX_DIN1_WIDTH;

  // Products are widened to this type before conversion.
  typedef logic [MAX_PROD_WIDTH-1:0] wide_t;

  typedef struct packed {
    wide_t dout;
    logic  sat;
  } sat_result_t;

  // Full product width for a given operand pair.
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1;
  endfunction

  // Low w bits hold the largest positive two's-complement value of width w.
  function automatic wide_t smax_word(input int w);
    wide_t one;
    one = {{(MAX_PROD_WIDTH-1){1'b0}}, 1'b1};
    return (one << (w - 1)) - one;
  endfunction

  // Low w bits hold the most negative two's-complement value of width w.
  function automatic wide_t smin_word(input int w);
    wide_t one;
    one = {{(MAX_PROD_WIDTH-1){1'b0}}, 1'b1};
    return one << (w - 1);
  endfunction

  // Convert an already sign/zero-extended product to dout_w bits.
  // The overflow flag is raised whenever the discarded upper bits are not a
  // plain extension of the kept bits; with saturate set the result clamps.
  function automatic sat_result_t sat_convert(input wide_t p, input logic is_signed,
                                              input int dout_w, input logic saturate);
    sat_result_t         res;
    wide_t               one;
    wide_t               mask;
    wide_t               upper;
    logic signed [MAX_PROD_WIDTH-1:0] ps;
    logic                ov;
    one  = {{(MAX_PROD_WIDTH-1){1'b0}}, 1'b1};
    mask = (one << dout_w) - one;
    ps   = $signed(p);
    if (is_signed) begin
      upper = wide_t'(ps >>> (dout_w - 1));
      ov    = (upper != {MAX_PROD_WIDTH{1'b0}}) && (upper != {MAX_PROD_WIDTH{1'b1}});
    end else begin
      upper = p >> dout_w;
      ov    = (upper != {MAX_PROD_WIDTH{1'b0}});
    end
    if (saturate && ov) begin
      if (is_signed) begin
        res.dout = p[MAX_PROD_WIDTH-1] ? smin_word(dout_w) : smax_word(dout_w);
      end else begin
        res.dout = mask;
      end
    end else begin
      res.dout = p & mask;
    end
    res.sat = ov;
    return res;
  endfunction

endpackage

// File: rtl/kernel2_mul_pipe_if.sv
// Producer/consumer handshake bundle of the kernel2 pipelined multiplier.
interface kernel2_mul_pipe_if
  import kernel2_mul_pkg::*;
#(
  parameter int din0_WIDTH = 12,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 22,
  parameter int TAG_WIDTH  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_signed;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] dout;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_sat;

  // Environment side: offers operations and consumes results.
  modport master (
    output in_valid, in_signed, din0, din1, in_tag, out_ready,
    input  in_ready, out_valid, dout, out_tag, out_sat
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_signed, din0, din1, in_tag, out_ready,
    output in_ready, out_valid, dout, out_tag, out_sat
  );
endinterface

// File: rtl/kernel2_mul_pipe_stage.sv
// One enable-gated register slice: a valid bit plus an opaque payload.
module kernel2_mul_pipe_stage
  import kernel2_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Shift on enable, hold otherwise; reset empties the slice.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end else begin
      valid_q <= valid_q;
      data_q  <= data_q;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/kernel2_mul_pipe.sv
// Streaming multiplier: operand register, optional retiming slices and a
// converted output register, all advanced by one global enable.
module kernel2_mul_pipe
  import kernel2_mul_pkg::*;
#(
  parameter int din0_WIDTH = 12,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 22,
  parameter int NUM_STAGE  = 3,
  parameter int SATURATE   = 0,
  parameter int TAG_WIDTH  = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  kernel2_mul_pipe_if.slave bus
);
  localparam int FULL_WIDTH = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int MID_W      = FULL_WIDTH + 1 + TAG_WIDTH;
  localparam int OUT_W      = dout_WIDTH + 1 + TAG_WIDTH;
  localparam int RETIME     = (NUM_STAGE >= 2) ? (NUM_STAGE - 2) : 0;

  logic                  en_s;
  logic                  out_valid_s;
  logic [OUT_W-1:0]      out_data_s;
  logic [din0_WIDTH-1:0] op_a_s;
  logic [din1_WIDTH-1:0] op_b_s;
  logic                  op_signed_s;
  logic [TAG_WIDTH-1:0]  op_tag_s;
  logic                  op_valid_s;
  logic [FULL_WIDTH-1:0] a_ext_s;
  logic [FULL_WIDTH-1:0] b_ext_s;
  logic [FULL_WIDTH-1:0] p_s;
  logic                  mid_valid_s [0:RETIME];
  logic [MID_W-1:0]      mid_data_s  [0:RETIME];
  logic [FULL_WIDTH-1:0] src_p_s;
  logic                  src_signed_s;
  logic [TAG_WIDTH-1:0]  src_tag_s;
  wide_t                 p_wide_s;
  sat_result_t           conv_s;
  logic                  unused_conv_s;

  // The whole pipe moves whenever the output slot is free or being drained.
  assign en_s         = !out_valid_s || bus.out_ready;
  assign bus.in_ready = en_s;

  if (NUM_STAGE == 1) begin : g_direct
    assign op_a_s      = bus.din0;
    assign op_b_s      = bus.din1;
    assign op_signed_s = bus.in_signed;
    assign op_tag_s    = bus.in_tag;
    assign op_valid_s  = bus.in_valid && en_s;
  end else begin : g_stage1
    logic [din0_WIDTH-1:0] a_q;
    logic [din1_WIDTH-1:0] b_q;
    logic                  signed_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  valid_q;
    logic                  valid_d;

    assign valid_d = bus.in_valid && en_s;

    // Capture operands, mode and tag of the offered operation.
    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        a_q      <= {din0_WIDTH{1'b0}};
        b_q      <= {din1_WIDTH{1'b0}};
        signed_q <= 1'b0;
        tag_q    <= {TAG_WIDTH{1'b0}};
        valid_q  <= 1'b0;
      end else if (en_s) begin
        a_q      <= bus.din0;
        b_q      <= bus.din1;
        signed_q <= bus.in_signed;
        tag_q    <= bus.in_tag;
        valid_q  <= valid_d;
      end else begin
        a_q      <= a_q;
        b_q      <= b_q;
        signed_q <= signed_q;
        tag_q    <= tag_q;
        valid_q  <= valid_q;
      end
    end

    assign op_a_s      = a_q;
    assign op_b_s      = b_q;
    assign op_signed_s = signed_q;
    assign op_tag_s    = tag_q;
    assign op_valid_s  = valid_q;
  end

  // Extend both operands to full width so one multiply serves both modes.
  assign a_ext_s = {{din1_WIDTH{op_signed_s & op_a_s[din0_WIDTH-1]}}, op_a_s};
  assign b_ext_s = {{din0_WIDTH{op_signed_s & op_b_s[din1_WIDTH-1]}}, op_b_s};
  assign p_s     = a_ext_s * b_ext_s;

  assign mid_valid_s[0] = op_valid_s;
  assign mid_data_s[0]  = {p_s, op_signed_s, op_tag_s};

  for (genvar g = 1; g <= RETIME; g++) begin : g_retime
    kernel2_mul_pipe_stage #(.WIDTH(MID_W)) u_stage (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .en_i     (en_s),
      .valid_i  (mid_valid_s[g-1]),
      .data_i   (mid_data_s[g-1]),
      .valid_o  (mid_valid_s[g]),
      .data_o   (mid_data_s[g])
    );
  end

  assign {src_p_s, src_signed_s, src_tag_s} = mid_data_s[RETIME];

  // Widen the product per its mode and convert it to the output format.
  always_comb begin
    p_wide_s = {MAX_PROD_WIDTH{src_signed_s & src_p_s[FULL_WIDTH-1]}};
    p_wide_s[FULL_WIDTH-1:0] = src_p_s;
    conv_s = sat_convert(p_wide_s, src_signed_s, dout_WIDTH, (SATURATE != 0));
  end

  assign unused_conv_s = ^conv_s.dout;

  kernel2_mul_pipe_stage #(.WIDTH(OUT_W)) u_out (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .en_i     (en_s),
    .valid_i  (mid_valid_s[RETIME]),
    .data_i   ({conv_s.dout[dout_WIDTH-1:0], conv_s.sat, src_tag_s}),
    .valid_o  (out_valid_s),
    .data_o   (out_data_s)
  );

  assign bus.out_valid = out_valid_s;
  assign {bus.dout, bus.out_sat, bus.out_tag} = out_data_s;
endmodule
